// File: rtl/nes_bus_arb.sv
// rtl/nes_bus_arb.sv - CPU / sprite-DMA system bus arbiter with RDY stall and get/put alignment
module nes_bus_arb #(
  parameter bit ALIGN_EN = 1'b1,
  parameter int CNT_W    = 10
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [15:0]      i_cpu_addr,
  input  logic             i_cpu_wn,
  input  logic [7:0]       i_cpu_wdata,
  output logic             o_cpu_rdy,
  input  logic             i_spr_req,
  output logic             o_spr_gnt,
  input  logic [15:0]      i_spr_addr,
  input  logic             i_spr_wn,
  input  logic [7:0]       i_spr_wdata,
  output logic [15:0]      o_bus_addr,
  output logic             o_bus_wn,
  output logic [7:0]       o_bus_wdata,
  output logic             o_parity,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_GRANT,
    S_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      o_cpu_rdy   <= 1'b1;
      o_spr_gnt   <= 1'b0;
      o_parity    <= 1'b0;
      o_busy      <= 1'b0;
      o_stall_cnt <= '0;
    end else begin
      o_parity <= ~o_parity;
      if (state != S_IDLE && o_stall_cnt != CNT_MAX)
        o_stall_cnt <= o_stall_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (i_spr_req) begin
            state       <= S_HALT;
            o_cpu_rdy   <= 1'b0;
            o_busy      <= 1'b1;
            o_stall_cnt <= '0;
          end
        end
        // The 6502 only honours RDY on reads, so wait out any write cycles.
        S_HALT: begin
          if (i_cpu_wn) begin
            if (ALIGN_EN && !o_parity) begin
              state <= S_ALIGN;
            end else begin
              state     <= S_GRANT;
              o_spr_gnt <= 1'b1;
            end
          end
        end
        S_ALIGN: begin
          state     <= S_GRANT;
          o_spr_gnt <= 1'b1;
        end
        S_GRANT: begin
          if (!i_spr_req) begin
            state     <= S_RELEASE;
            o_spr_gnt <= 1'b0;
          end
        end
        S_RELEASE: begin
          state     <= S_IDLE;
          o_cpu_rdy <= 1'b1;
          o_busy    <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          o_cpu_rdy <= 1'b1;
          o_spr_gnt <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

  // ALIGN and RELEASE park the bus on a harmless RAM read of $0000.
  always_comb begin
    o_bus_addr  = i_cpu_addr;
    o_bus_wn    = i_cpu_wn;
    o_bus_wdata = i_cpu_wdata;
    case (state)
      S_GRANT: begin
        o_bus_addr  = i_spr_addr;
        o_bus_wn    = i_spr_wn;
        o_bus_wdata = i_spr_wdata;
      end
      S_ALIGN, S_RELEASE: begin
        o_bus_addr  = 16'h0000;
        o_bus_wn    = 1'b1;
        o_bus_wdata = 8'h00;
      end
      default: begin
        o_bus_addr  = i_cpu_addr;
        o_bus_wn    = i_cpu_wn;
        o_bus_wdata = i_cpu_wdata;
      end
    endcase
  end

endmodule

// File: tb/tb_nes_bus_arb.sv
// tb/tb_nes_bus_arb.sv - directed checks of the CPU / sprite-DMA bus arbiter
module tb_nes_bus_arb;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [15:0] i_cpu_addr;
  logic        i_cpu_wn;
  logic [7:0]  i_cpu_wdata;
  logic        o_cpu_rdy;
  logic        i_spr_req;
  logic        o_spr_gnt;
  logic [15:0] i_spr_addr;
  logic        i_spr_wn;
  logic [7:0]  i_spr_wdata;
  logic [15:0] o_bus_addr;
  logic        o_bus_wn;
  logic [7:0]  o_bus_wdata;
  logic        o_parity;
  logic        o_busy;
  logic [9:0]  o_stall_cnt;

  nes_bus_arb #(.ALIGN_EN(1'b1), .CNT_W(10)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_wn    (i_cpu_wn),
    .i_cpu_wdata (i_cpu_wdata),
    .o_cpu_rdy   (o_cpu_rdy),
    .i_spr_req   (i_spr_req),
    .o_spr_gnt   (o_spr_gnt),
    .i_spr_addr  (i_spr_addr),
    .i_spr_wn    (i_spr_wn),
    .i_spr_wdata (i_spr_wdata),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wn    (o_bus_wn),
    .o_bus_wdata (o_bus_wdata),
    .o_parity    (o_parity),
    .o_busy      (o_busy),
    .o_stall_cnt (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_par  = 1'b0;

  typedef struct {
    logic [15:0] addr;
    logic        wn;
    logic [7:0]  wdata;
    logic [15:0] exp_addr;
    logic        exp_wn;
    logic [7:0]  exp_wdata;
    logic        exp_par;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    exp_par = ~exp_par;
    chk("parity", 32'(o_parity), 32'(exp_par));
  endtask

  task automatic run_dma(input string tag, input bit req_par, input int n_wr, input int n_grant,
                         input int rst_at, input bit rel_req, input int exp_stall);
    bit aln;
    i_spr_req  = 1'b0;
    i_cpu_wn   = 1'b1;
    i_cpu_addr = 16'hC000;
    if (exp_par != req_par) step();
    i_spr_req = 1'b1;
    step();
    chk({tag, "_halt_rdy"}, 32'(o_cpu_rdy), 0);
    chk({tag, "_halt_busy"}, 32'(o_busy), 1);
    chk({tag, "_halt_gnt"}, 32'(o_spr_gnt), 0);
    chk({tag, "_halt_cnt"}, 32'(o_stall_cnt), 0);
    for (int k = 0; k < n_wr; k++) begin
      i_cpu_wn    = 1'b0;
      i_cpu_addr  = 16'h01FD - 16'(k);
      i_cpu_wdata = 8'h10 + 8'(k);
      #1;
      chk({tag, "_wr_addr"}, 32'(o_bus_addr), 32'(16'h01FD - 16'(k)));
      chk({tag, "_wr_wn"}, 32'(o_bus_wn), 0);
      chk({tag, "_wr_wdata"}, 32'(o_bus_wdata), 32'(8'h10 + 8'(k)));
      step();
      chk({tag, "_wr_gnt"}, 32'(o_spr_gnt), 0);
    end
    i_cpu_wn   = 1'b1;
    i_cpu_addr = 16'hC100;
    aln = (exp_par == 1'b0);
    step();
    if (aln) begin
      chk({tag, "_aln_gnt"}, 32'(o_spr_gnt), 0);
      chk({tag, "_aln_addr"}, 32'(o_bus_addr), 0);
      chk({tag, "_aln_wn"}, 32'(o_bus_wn), 1);
      chk({tag, "_aln_wdata"}, 32'(o_bus_wdata), 0);
      step();
    end
    chk({tag, "_gnt"}, 32'(o_spr_gnt), 1);
    chk({tag, "_gnt_par"}, 32'(o_parity), 0);
    chk({tag, "_gnt_rdy"}, 32'(o_cpu_rdy), 0);
    i_spr_addr  = 16'h2004;
    i_spr_wn    = 1'b0;
    i_spr_wdata = 8'hA5;
    i_cpu_addr  = 16'hFFFF;
    i_cpu_wn    = 1'b0;
    i_cpu_wdata = 8'h3C;
    #1;
    chk({tag, "_mux_addr"}, 32'(o_bus_addr), 32'h2004);
    chk({tag, "_mux_wn"}, 32'(o_bus_wn), 0);
    chk({tag, "_mux_wdata"}, 32'(o_bus_wdata), 32'hA5);
    for (int g = 1; g <= n_grant; g++) begin
      if (g == rst_at) begin
        i_rstn = 1'b0;
        #1;
        chk({tag, "_rst_gnt"}, 32'(o_spr_gnt), 0);
        chk({tag, "_rst_rdy"}, 32'(o_cpu_rdy), 1);
        chk({tag, "_rst_cnt"}, 32'(o_stall_cnt), 0);
        chk({tag, "_rst_busy"}, 32'(o_busy), 0);
        chk({tag, "_rst_par"}, 32'(o_parity), 0);
        chk({tag, "_rst_bus"}, 32'(o_bus_addr), 32'hFFFF);
        i_spr_req = 1'b0;
        i_cpu_wn  = 1'b1;
        @(negedge i_clk);
        i_rstn  = 1'b1;
        exp_par = 1'b0;
        return;
      end
      if (g == 2) begin
        i_spr_addr  = 16'h0300;
        i_spr_wn    = 1'b1;
        i_spr_wdata = 8'h00;
        #1;
        chk({tag, "_mux2_addr"}, 32'(o_bus_addr), 32'h0300);
        chk({tag, "_mux2_wn"}, 32'(o_bus_wn), 1);
      end
      i_spr_req = (g < n_grant);
      step();
    end
    chk({tag, "_rel_gnt"}, 32'(o_spr_gnt), 0);
    chk({tag, "_rel_rdy"}, 32'(o_cpu_rdy), 0);
    chk({tag, "_rel_busy"}, 32'(o_busy), 1);
    chk({tag, "_rel_addr"}, 32'(o_bus_addr), 0);
    chk({tag, "_rel_wn"}, 32'(o_bus_wn), 1);
    i_cpu_wn   = 1'b1;
    i_cpu_addr = 16'h8123;
    i_spr_req  = rel_req;
    step();
    chk({tag, "_idle_rdy"}, 32'(o_cpu_rdy), 1);
    chk({tag, "_idle_busy"}, 32'(o_busy), 0);
    chk({tag, "_idle_gnt"}, 32'(o_spr_gnt), 0);
    chk({tag, "_stall_cnt"}, 32'(o_stall_cnt), 32'(exp_stall));
    chk({tag, "_idle_bus"}, 32'(o_bus_addr), 32'h8123);
  endtask

  initial begin
    bit aln;
    i_rstn      = 1'b0;
    i_cpu_addr  = 16'h0000;
    i_cpu_wn    = 1'b1;
    i_cpu_wdata = 8'h00;
    i_spr_req   = 1'b0;
    i_spr_addr  = 16'h0000;
    i_spr_wn    = 1'b1;
    i_spr_wdata = 8'h00;

    vecs[0] = '{16'h8123, 1'b1, 8'h00, 16'h8123, 1'b1, 8'h00, 1'b1};
    vecs[1] = '{16'h0000, 1'b1, 8'h00, 16'h0000, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{16'h2002, 1'b1, 8'hFF, 16'h2002, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{16'h01FF, 1'b0, 8'h42, 16'h01FF, 1'b0, 8'h42, 1'b0};
    vecs[4] = '{16'hFFFC, 1'b1, 8'h00, 16'hFFFC, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{16'h4014, 1'b0, 8'h02, 16'h4014, 1'b0, 8'h02, 1'b0};
    vecs[6] = '{16'h0700, 1'b1, 8'h5A, 16'h0700, 1'b1, 8'h5A, 1'b1};
    vecs[7] = '{16'hC000, 1'b1, 8'h00, 16'hC000, 1'b1, 8'h00, 1'b0};

    repeat (2) @(negedge i_clk);
    chk("reset_par", 32'(o_parity), 0);
    chk("reset_rdy", 32'(o_cpu_rdy), 1);
    chk("reset_gnt", 32'(o_spr_gnt), 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_cnt", 32'(o_stall_cnt), 0);
    i_rstn  = 1'b1;
    exp_par = 1'b0;

    for (int i = 0; i < 8; i++) begin
      i_cpu_addr  = vecs[i].addr;
      i_cpu_wn    = vecs[i].wn;
      i_cpu_wdata = vecs[i].wdata;
      #1;
      chk("idle_bus_addr", 32'(o_bus_addr), 32'(vecs[i].exp_addr));
      chk("idle_bus_wn", 32'(o_bus_wn), 32'(vecs[i].exp_wn));
      chk("idle_bus_wdata", 32'(o_bus_wdata), 32'(vecs[i].exp_wdata));
      @(posedge i_clk);
      #1;
      exp_par = vecs[i].exp_par;
      chk("idle_par", 32'(o_parity), 32'(vecs[i].exp_par));
      chk("idle_rdy", 32'(o_cpu_rdy), 1);
      chk("idle_gnt", 32'(o_spr_gnt), 0);
    end

    run_dma("align",   1'b1, 0, 512, 0,   1'b0, 515);
    run_dma("noalign", 1'b0, 0, 512, 0,   1'b0, 514);
    run_dma("writes",  1'b1, 3, 4,   0,   1'b0, 9);
    run_dma("reset",   1'b0, 0, 512, 100, 1'b0, 0);
    run_dma("postrst", 1'b1, 0, 512, 0,   1'b0, 515);
    run_dma("sat",     1'b0, 0, 1100, 0,  1'b0, 1023);
    run_dma("relreq",  1'b1, 0, 2,   0,   1'b1, 5);

    // req held through RELEASE is taken from IDLE, then dropped in HALT: no abort path
    step();
    chk("late_halt_busy", 32'(o_busy), 1);
    chk("late_halt_rdy", 32'(o_cpu_rdy), 0);
    chk("late_halt_cnt", 32'(o_stall_cnt), 0);
    i_spr_req = 1'b0;
    i_cpu_wn  = 1'b1;
    aln = (exp_par == 1'b0);
    step();
    if (aln) begin
      chk("late_aln_gnt", 32'(o_spr_gnt), 0);
      step();
    end
    chk("late_gnt", 32'(o_spr_gnt), 1);
    step();
    chk("late_rel_gnt", 32'(o_spr_gnt), 0);
    chk("late_rel_busy", 32'(o_busy), 1);
    step();
    chk("late_idle_rdy", 32'(o_cpu_rdy), 1);
    chk("late_cnt", 32'(o_stall_cnt), aln ? 32'd4 : 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
